rv_iopmp_check_requester: RTL and testbench
===========================================

# rv_iopmp_check_requester

Initiator side of the IOPMP transaction-check handshake. Accepts one AXI-style burst request (address, length, size, burst type, SID, access type), splits it into per-beat checks, issues each to the IOPMP transaction checker through its enable/ready/valid interface, and returns a single allow/deny verdict for the whole burst. It also holds a sticky first-error record for the IOPMP error-capture registers. It sits between the bus-port front end and the transaction checker.

## Interface
- ADDR_WIDTH, 64, request/check address width
- DATA_WIDTH, 64, bus data width; max beat = DATA_WIDTH/8 bytes
- SID_WIDTH, 8, source-ID width
- LEN_WIDTH, 8, burst length field width (beats-1)
- clk_i  in  1  rising-edge clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i / req_ready_o  in/out  1  burst request handshake
- req_addr_i  in  ADDR_WIDTH  first-beat address
- req_len_i  in  LEN_WIDTH  beats-1
- req_size_i  in  3  log2(bytes/beat), ≤ log2(DATA_WIDTH/8)
- req_burst_i  in  rv_iopmp_pkg::burst_t  FIXED or INCR
- req_sid_i  in  SID_WIDTH  requester SID
- req_access_i  in  rv_iopmp_pkg::access_t  read/write/execute
- chk_en_o  out  1  check request to checker
- chk_ready_i  in  1  checker idle/ready
- chk_addr_o  out  ADDR_WIDTH; chk_num_bytes_o  out  $clog2(DATA_WIDTH/8)+1; chk_sid_o  out  SID_WIDTH; chk_access_o  out  access_t
- chk_valid_i  in  1  checker result pulse
- chk_allow_i  in  1  checker verdict, meaningful with chk_valid_i
- chk_err_i  in  rv_iopmp_pkg::error_capture_t  checker error info
- rsp_valid_o / rsp_ready_i  out/in  1  burst verdict handshake
- rsp_allow_o  out  1  1 = whole burst allowed
- rsp_fail_beat_o  out  LEN_WIDTH  index of first denied beat (0 if allowed)
- err_valid_o  out  1  sticky error record valid
- err_record_o  out  error_capture_t  first captured error
- err_overflow_o  out  1  sticky: error dropped while record held
- err_clear_i  in  1  clears err_valid_o, err_overflow_o

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i: latch request, beat=0, cur_addr=req_addr_i; go ISSUE.
- ISSUE: chk_en_o=1 with chk_* driven from registers; held until chk_ready_i=1. Handshake completes in a cycle with chk_en_o&chk_ready_i; go WAIT.
- WAIT: on chk_valid_i: deny (chk_allow_i=0) → RESP, allow=0, fail_beat=beat. Allow and last beat → RESP, allow=1, fail_beat=0. Allow otherwise → beat+1, advance address, ISSUE.
- WAIT deny without result: if chk_ready_i returns high after ≥1 cycle low with no chk_valid_i seen → treat as deny (no error record).
- RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; then IDLE.
- Beat count: INCR = req_len_i+1 checks; FIXED = exactly one check.
- Beat addressing: first beat num_bytes = 2^size − (addr mod 2^size); later beats aligned, num_bytes = 2^size. Next addr = align(addr, 2^size) + 2^size, modulo 2^ADDR_WIDTH (wraps silently; 4 KiB crossing not checked).
- Error record: on chk_valid_i & chk_err_i.error_detected: if !err_valid_o, capture into err_record_o, set err_valid_o; else set err_overflow_o. err_clear_i and new error same cycle → clear then capture (err_valid_o stays 1, new record, overflow 0).

## Timing
- Reset: state IDLE; req_ready_o=1 post-reset; all other outputs 0, err_record_o all-zero.
- Reset mid-burst: abandon burst immediately; no response issued; error record cleared.
- Request accepted at edge 0 → chk_en_o high cycle 1. Result pulse in cycle N → next ISSUE cycle N+1 or rsp_valid_o cycle N+1.
- All outputs registered except chk_en_o/req_ready_o (decoded from state register).
- chk_valid_i outside WAIT ignored for verdict; still feeds error record.

## Structure
- rv_iopmp_pkg: add burst_t (BURST_FIXED=0, BURST_INCR=1), req_state_t; reuse access_t, error_capture_t.
- Sub-module rv_iopmp_beat_addr_gen: combinational next-address and num_bytes from addr, size, first-beat flag.

## Test plan
- INCR, addr 0x1000, len 3, size 3, checker allows all → 4 checks at 0x1000/08/10/18, num_bytes 8; rsp_allow_o=1, fail_beat 0.
- INCR, addr 0x1003, len 1, size 2 → checks 0x1003 num_bytes 1, then 0x1004 num_bytes 4.
- Deny on beat 2 of len 5 with error_detected → rsp_allow_o=0, fail_beat 2, only 3 checks issued, err_valid_o=1 with that record.
- Second error while record held → err_overflow_o=1, record unchanged; err_clear_i → both 0.
- FIXED, len 7 → exactly one check; chk_ready_i held low 3 cycles → chk_en_o held, request stable.
- Assert rst_i during WAIT → all outputs 0 next cycle, req_ready_o=1 after release, no rsp_valid_o.

Source files
------------

// File: rtl/rv_iopmp_pkg.sv
// rv_iopmp_pkg
//   Shared types for the IOPMP requester/checker slice: access types, the
//   error-capture record reported by the transaction checker, the burst type
//   of an incoming bus request and the requester FSM state encoding.
package rv_iopmp_pkg;

    localparam int ERR_SID_WIDTH  = 8;
    localparam int ERR_ADDR_WIDTH = 64;

    typedef enum logic [1:0] {
        ACC_READ  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_EXEC  = 2'd2
    } access_t;

    typedef enum logic {
        BURST_FIXED = 1'b0,
        BURST_INCR  = 1'b1
    } burst_t;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_ISSUE = 2'd1,
        REQ_WAIT  = 2'd2,
        REQ_RESP  = 2'd3
    } req_state_t;

    typedef struct packed {
        logic                      error_detected;
        logic [2:0]                err_type;
        access_t                   access;
        logic [ERR_SID_WIDTH-1:0]  sid;
        logic [ERR_ADDR_WIDTH-1:0] addr;
    } error_capture_t;

endpackage

// File: rtl/rv_iopmp_beat_addr_gen.sv
// rv_iopmp_beat_addr_gen
//   Combinational beat address helper. For the current beat address and
//   log2 beat size it gives the byte count of this beat (the first beat may be
//   unaligned and only covers up to the next size boundary) and the address of
//   the following aligned beat. Address arithmetic wraps modulo 2^ADDR_WIDTH.
//   Ports:
//     addr_i      current beat address
//     size_i      log2(bytes per beat)
//     first_i     1 = this is the first beat of the burst
//     num_bytes_o bytes covered by this beat
//     next_addr_o aligned address of the next beat
module rv_iopmp_beat_addr_gen #(
    parameter int ADDR_WIDTH = 64,
    parameter int NB_WIDTH   = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic                  first_i,
    output logic [NB_WIDTH-1:0]   num_bytes_o,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] beat_bytes;
    logic [ADDR_WIDTH-1:0] offs_mask;

    assign beat_bytes  = ADDR_WIDTH'(1) << size_i;
    assign offs_mask   = beat_bytes - ADDR_WIDTH'(1);
    assign next_addr_o = (addr_i & ~offs_mask) + beat_bytes;
    assign num_bytes_o = first_i ? NB_WIDTH'(beat_bytes - (addr_i & offs_mask))
                                 : NB_WIDTH'(beat_bytes);

endmodule

// File: rtl/rv_iopmp_check_requester.sv
// rv_iopmp_check_requester
//   Initiator side of the IOPMP transaction-check handshake. Takes one burst
//   request, issues one check per beat to the transaction checker, and returns
//   a single allow/deny verdict for the burst. Keeps a sticky first-error
//   record with an overflow flag for the error-capture registers.
//   Ports:
//     clk_i, rst_i               clock, async active-high reset
//     req_*                      burst request (valid/ready)
//     chk_en_o/chk_ready_i       per-beat check request to the checker
//     chk_addr_o .. chk_access_o per-beat check attributes
//     chk_valid_i/chk_allow_i    checker result pulse and verdict
//     chk_err_i                  checker error-capture info
//     rsp_*                      burst verdict (valid/ready)
//     err_valid_o/err_record_o   sticky first error record
//     err_overflow_o             error dropped while record held
//     err_clear_i                clears the error record flags
module rv_iopmp_check_requester
    import rv_iopmp_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int SID_WIDTH  = 8,
    parameter int LEN_WIDTH  = 8,
    localparam int NB_WIDTH  = $clog2(DATA_WIDTH/8) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_WIDTH-1:0]  req_len_i,
    input  logic [2:0]            req_size_i,
    input  burst_t                req_burst_i,
    input  logic [SID_WIDTH-1:0]  req_sid_i,
    input  access_t               req_access_i,
    output logic                  chk_en_o,
    input  logic                  chk_ready_i,
    output logic [ADDR_WIDTH-1:0] chk_addr_o,
    output logic [NB_WIDTH-1:0]   chk_num_bytes_o,
    output logic [SID_WIDTH-1:0]  chk_sid_o,
    output access_t               chk_access_o,
    input  logic                  chk_valid_i,
    input  logic                  chk_allow_i,
    input  error_capture_t        chk_err_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_allow_o,
    output logic [LEN_WIDTH-1:0]  rsp_fail_beat_o,
    output logic                  err_valid_o,
    output error_capture_t        err_record_o,
    output logic                  err_overflow_o,
    input  logic                  err_clear_i
);

    typedef struct packed {
        logic [LEN_WIDTH-1:0] len;
        logic [2:0]           size;
        burst_t               burst;
    } burst_req_t;

    req_state_t            state_q;
    burst_req_t            req_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic                  ready_low_q;   // checker dropped ready since issue
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic [2:0]            gen_size;
    logic [NB_WIDTH-1:0]   gen_num_bytes;
    logic [ADDR_WIDTH-1:0] gen_next_addr;

    assign req_ready_o = (state_q == REQ_IDLE);
    assign chk_en_o    = (state_q == REQ_ISSUE);

    // FIXED bursts need a single check regardless of length.
    assign last_beat = (req_q.burst == BURST_FIXED) || (beat_q == req_q.len);

    // In IDLE the generator sizes the first beat straight from the request;
    // elsewhere it steps from the beat currently on the check port.
    assign gen_addr = (state_q == REQ_IDLE) ? req_addr_i : chk_addr_o;
    assign gen_size = (state_q == REQ_IDLE) ? req_size_i : req_q.size;

    rv_iopmp_beat_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_WIDTH   (NB_WIDTH)
    ) u_beat_addr_gen (
        .addr_i      (gen_addr),
        .size_i      (gen_size),
        .first_i     (state_q == REQ_IDLE),
        .num_bytes_o (gen_num_bytes),
        .next_addr_o (gen_next_addr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= REQ_IDLE;
            req_q           <= '0;
            beat_q          <= '0;
            ready_low_q     <= 1'b0;
            chk_addr_o      <= '0;
            chk_num_bytes_o <= '0;
            chk_sid_o       <= '0;
            chk_access_o    <= ACC_READ;
            rsp_valid_o     <= 1'b0;
            rsp_allow_o     <= 1'b0;
            rsp_fail_beat_o <= '0;
        end else begin
            case (state_q)
                REQ_IDLE: begin
                    if (req_valid_i) begin
                        req_q.len       <= req_len_i;
                        req_q.size      <= req_size_i;
                        req_q.burst     <= req_burst_i;
                        beat_q          <= '0;
                        chk_addr_o      <= req_addr_i;
                        chk_num_bytes_o <= gen_num_bytes;
                        chk_sid_o       <= req_sid_i;
                        chk_access_o    <= req_access_i;
                        state_q         <= REQ_ISSUE;
                    end
                end
                REQ_ISSUE: begin
                    if (chk_ready_i) begin
                        ready_low_q <= 1'b0;
                        state_q     <= REQ_WAIT;
                    end
                end
                REQ_WAIT: begin
                    if (chk_valid_i) begin
                        if (!chk_allow_i) begin
                            rsp_allow_o     <= 1'b0;
                            rsp_fail_beat_o <= beat_q;
                            rsp_valid_o     <= 1'b1;
                            state_q         <= REQ_RESP;
                        end else if (last_beat) begin
                            rsp_allow_o     <= 1'b1;
                            rsp_fail_beat_o <= '0;
                            rsp_valid_o     <= 1'b1;
                            state_q         <= REQ_RESP;
                        end else begin
                            beat_q          <= beat_q + LEN_WIDTH'(1);
                            chk_addr_o      <= gen_next_addr;
                            chk_num_bytes_o <= gen_num_bytes;
                            state_q         <= REQ_ISSUE;
                        end
                    end else if (chk_ready_i && ready_low_q) begin
                        // Checker went busy and came back idle without a
                        // result: the check was lost, fail the burst safe.
                        rsp_allow_o     <= 1'b0;
                        rsp_fail_beat_o <= beat_q;
                        rsp_valid_o     <= 1'b1;
                        state_q         <= REQ_RESP;
                    end else if (!chk_ready_i) begin
                        ready_low_q <= 1'b1;
                    end
                end
                REQ_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state_q     <= REQ_IDLE;
                    end
                end
                default: state_q <= REQ_IDLE;
            endcase
        end
    end

    // Sticky error record; fed by any checker result, not just ones the FSM
    // is waiting on. A clear in the same cycle as a new error lets the new
    // error take the freed record.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_valid_o    <= 1'b0;
            err_overflow_o <= 1'b0;
            err_record_o   <= '0;
        end else if (chk_valid_i && chk_err_i.error_detected) begin
            if (!err_valid_o || err_clear_i) begin
                err_record_o   <= chk_err_i;
                err_valid_o    <= 1'b1;
                err_overflow_o <= 1'b0;
            end else begin
                err_overflow_o <= 1'b1;
            end
        end else if (err_clear_i) begin
            err_valid_o    <= 1'b0;
            err_overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_iopmp_check_requester.sv
module tb_rv_iopmp_check_requester;
    import rv_iopmp_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [63:0]    req_addr_i = '0;
    logic [7:0]     req_len_i = '0;
    logic [2:0]     req_size_i = '0;
    burst_t         req_burst_i = BURST_INCR;
    logic [7:0]     req_sid_i = '0;
    access_t        req_access_i = ACC_READ;
    logic           chk_en_o;
    logic           chk_ready_i;
    logic [63:0]    chk_addr_o;
    logic [3:0]     chk_num_bytes_o;
    logic [7:0]     chk_sid_o;
    access_t        chk_access_o;
    logic           chk_valid_i = 1'b0;
    logic           chk_allow_i = 1'b0;
    error_capture_t chk_err_i = '0;
    logic           rsp_valid_o;
    logic           rsp_ready_i = 1'b1;
    logic           rsp_allow_o;
    logic [7:0]     rsp_fail_beat_o;
    logic           err_valid_o;
    error_capture_t err_record_o;
    logic           err_overflow_o;
    logic           err_clear_i = 1'b0;

    logic rsp_rdy   = 1'b1;   // checker model's ready
    logic stim_hold = 1'b0;   // stimulus-forced checker stall
    assign chk_ready_i = rsp_rdy & ~stim_hold;

    always #5 clk = ~clk;

    rv_iopmp_check_requester dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_size_i(req_size_i),
        .req_burst_i(req_burst_i), .req_sid_i(req_sid_i), .req_access_i(req_access_i),
        .chk_en_o(chk_en_o), .chk_ready_i(chk_ready_i), .chk_addr_o(chk_addr_o),
        .chk_num_bytes_o(chk_num_bytes_o), .chk_sid_o(chk_sid_o), .chk_access_o(chk_access_o),
        .chk_valid_i(chk_valid_i), .chk_allow_i(chk_allow_i), .chk_err_i(chk_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_allow_o(rsp_allow_o),
        .rsp_fail_beat_o(rsp_fail_beat_o), .err_valid_o(err_valid_o),
        .err_record_o(err_record_o), .err_overflow_o(err_overflow_o),
        .err_clear_i(err_clear_i)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  nb;
        logic [7:0]  sid;
        access_t     acc;
    } chk_exp_t;
    typedef struct packed {
        logic       allow;
        logic [7:0] fb;
    } rsp_exp_t;
    typedef struct packed {
        logic           allow;
        logic           nores;
        error_capture_t err;
    } verdict_t;

    chk_exp_t exp_chk[$];
    rsp_exp_t exp_rsp[$];
    verdict_t vq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_c(input logic [63:0] a, input logic [3:0] nb, input logic [7:0] sid, input access_t acc);
        chk_exp_t e;
        e.addr = a; e.nb = nb; e.sid = sid; e.acc = acc;
        exp_chk.push_back(e);
    endtask

    task automatic exp_r(input logic allow, input logic [7:0] fb);
        rsp_exp_t e;
        e.allow = allow; e.fb = fb;
        exp_rsp.push_back(e);
    endtask

    task automatic verd(input logic allow, input logic nores, input error_capture_t err);
        verdict_t v;
        v.allow = allow; v.nores = nores; v.err = err;
        vq.push_back(v);
    endtask

    task automatic send(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                        input burst_t b, input logic [7:0] sid, input access_t acc);
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_addr_i = a; req_len_i = len; req_size_i = sz;
        req_burst_i = b; req_sid_i = sid; req_access_i = acc;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req_ready_o && exp_rsp.size() == 0 && exp_chk.size() == 0) break;
        end
        if (k == 300) begin
            n_vec++; n_err++;
            $display("FAIL %s: timeout, pending chk=%0d rsp=%0d", name, exp_chk.size(), exp_rsp.size());
            exp_chk.delete(); exp_rsp.delete();
        end
    endtask

    // Checker model: on each handshake go busy one cycle, then return ready
    // together with the queued result (or without one for a lost check).
    initial begin : checker_model
        verdict_t v;
        forever begin
            @(negedge clk);
            if (!rst && chk_en_o && chk_ready_i) begin
                if (vq.size() > 0) v = vq.pop_front();
                else begin v = '0; v.allow = 1'b1; end
                @(posedge clk); #1;
                rsp_rdy = 1'b0;
                @(posedge clk); #1;
                rsp_rdy = 1'b1;
                if (!v.nores) begin
                    chk_valid_i = 1'b1; chk_allow_i = v.allow; chk_err_i = v.err;
                end
                @(posedge clk); #1;
                chk_valid_i = 1'b0; chk_allow_i = 1'b0; chk_err_i = '0;
            end
        end
    end

    // Scoreboard monitor: compare every check handshake and every response.
    initial begin : monitor
        chk_exp_t ec;
        rsp_exp_t er;
        forever begin
            @(negedge clk);
            if (!rst && chk_en_o && chk_ready_i) begin
                if (exp_chk.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL chk_unexpected: addr %0h", chk_addr_o);
                end else begin
                    ec = exp_chk.pop_front();
                    check("chk_addr", chk_addr_o, ec.addr);
                    check("chk_num_bytes", chk_num_bytes_o, ec.nb);
                    check("chk_sid", chk_sid_o, ec.sid);
                    check("chk_access", chk_access_o, ec.acc);
                end
            end
            if (!rst && rsp_valid_o && rsp_ready_i) begin
                if (exp_rsp.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rsp_unexpected: allow %0b beat %0d", rsp_allow_o, rsp_fail_beat_o);
                end else begin
                    er = exp_rsp.pop_front();
                    check("rsp_allow", rsp_allow_o, er.allow);
                    check("rsp_fail_beat", rsp_fail_beat_o, er.fb);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        error_capture_t e0, e1, e2, e3;
        e0 = '0;
        e1 = '{error_detected: 1'b1, err_type: 3'd2, access: ACC_WRITE, sid: 8'h11, addr: 64'h2010};
        e2 = '{error_detected: 1'b1, err_type: 3'd1, access: ACC_READ,  sid: 8'h22, addr: 64'h3000};
        e3 = '{error_detected: 1'b1, err_type: 3'd3, access: ACC_EXEC,  sid: 8'h33, addr: 64'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_chk_en", chk_en_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_chk_addr", chk_addr_o, 64'h0);
        check("rst_err_valid", err_valid_o, 1'b0);
        check("rst_err_ovf", err_overflow_o, 1'b0);
        check("rst_err_record", err_record_o, e0);

        // INCR aligned, all allowed
        exp_c(64'h1000, 4'd8, 8'h01, ACC_READ);
        exp_c(64'h1008, 4'd8, 8'h01, ACC_READ);
        exp_c(64'h1010, 4'd8, 8'h01, ACC_READ);
        exp_c(64'h1018, 4'd8, 8'h01, ACC_READ);
        for (int i = 0; i < 4; i++) verd(1'b1, 1'b0, e0);
        exp_r(1'b1, 8'd0);
        send(64'h1000, 8'd3, 3'd3, BURST_INCR, 8'h01, ACC_READ);
        wait_idle("incr_aligned");

        // INCR unaligned first beat
        exp_c(64'h1003, 4'd1, 8'h02, ACC_WRITE);
        exp_c(64'h1004, 4'd4, 8'h02, ACC_WRITE);
        verd(1'b1, 1'b0, e0); verd(1'b1, 1'b0, e0);
        exp_r(1'b1, 8'd0);
        send(64'h1003, 8'd1, 3'd2, BURST_INCR, 8'h02, ACC_WRITE);
        wait_idle("incr_unaligned");

        // Deny on beat 2 of 6 with error
        exp_c(64'h2000, 4'd8, 8'h11, ACC_WRITE);
        exp_c(64'h2008, 4'd8, 8'h11, ACC_WRITE);
        exp_c(64'h2010, 4'd8, 8'h11, ACC_WRITE);
        verd(1'b1, 1'b0, e0); verd(1'b1, 1'b0, e0); verd(1'b0, 1'b0, e1);
        exp_r(1'b0, 8'd2);
        send(64'h2000, 8'd5, 3'd3, BURST_INCR, 8'h11, ACC_WRITE);
        wait_idle("deny_beat2");
        check("err1_valid", err_valid_o, 1'b1);
        check("err1_record", err_record_o, e1);
        check("err1_ovf", err_overflow_o, 1'b0);

        // Second error while record held -> overflow
        exp_c(64'h3000, 4'd4, 8'h22, ACC_READ);
        verd(1'b0, 1'b0, e2);
        exp_r(1'b0, 8'd0);
        send(64'h3000, 8'd0, 3'd2, BURST_INCR, 8'h22, ACC_READ);
        wait_idle("deny_second");
        check("err2_valid", err_valid_o, 1'b1);
        check("err2_record_kept", err_record_o, e1);
        check("err2_ovf", err_overflow_o, 1'b1);
        @(posedge clk); #1 err_clear_i = 1'b1;
        @(posedge clk); #1 err_clear_i = 1'b0;
        @(negedge clk);
        check("clr_valid", err_valid_o, 1'b0);
        check("clr_ovf", err_overflow_o, 1'b0);

        // FIXED len 7 -> one check; checker stalls with ready low
        exp_c(64'h4000, 4'd8, 8'h05, ACC_WRITE);
        verd(1'b1, 1'b0, e0);
        exp_r(1'b1, 8'd0);
        stim_hold = 1'b1;
        send(64'h4000, 8'd7, 3'd3, BURST_FIXED, 8'h05, ACC_WRITE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_en_held", chk_en_o, 1'b1);
            check("stall_addr", chk_addr_o, 64'h4000);
        end
        @(posedge clk); #1 stim_hold = 1'b0;
        wait_idle("fixed_stall");

        // Checker returns ready without a result -> deny, no error record
        exp_c(64'h5000, 4'd8, 8'h06, ACC_READ);
        exp_c(64'h5008, 4'd8, 8'h06, ACC_READ);
        verd(1'b1, 1'b0, e0); verd(1'b0, 1'b1, e0);
        exp_r(1'b0, 8'd1);
        send(64'h5000, 8'd2, 3'd3, BURST_INCR, 8'h06, ACC_READ);
        wait_idle("lost_result");
        check("lost_no_err", err_valid_o, 1'b0);

        // Address wraps to zero; deny there with error
        exp_c(64'hFFFF_FFFF_FFFF_FFF8, 4'd8, 8'h33, ACC_EXEC);
        exp_c(64'h0, 4'd8, 8'h33, ACC_EXEC);
        verd(1'b1, 1'b0, e0); verd(1'b0, 1'b0, e3);
        exp_r(1'b0, 8'd1);
        send(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, BURST_INCR, 8'h33, ACC_EXEC);
        wait_idle("addr_wrap");
        check("err3_valid", err_valid_o, 1'b1);
        check("err3_record", err_record_o, e3);

        // Reset while waiting for a result
        exp_c(64'h6000, 4'd8, 8'h07, ACC_READ);
        verd(1'b1, 1'b0, e0);
        send(64'h6000, 8'd3, 3'd3, BURST_INCR, 8'h07, ACC_READ);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_chk_en", chk_en_o, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
        check("mid_rst_chk_addr", chk_addr_o, 64'h0);
        check("mid_rst_err_valid", err_valid_o, 1'b0);
        check("mid_rst_err_record", err_record_o, e0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_req_ready", req_ready_o, 1'b1);
            check("post_rst_rsp_valid", rsp_valid_o, 1'b0);
        end

        check("end_chk_queue", exp_chk.size(), 0);
        check("end_rsp_queue", exp_rsp.size(), 0);
        check("end_verdict_queue", vq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
